// File: rtl/seq_multiplier.sv
// 16x16 unsigned shift-and-add multiplier: one partial product per clock,
// fixed 16-step busy period, start/ready handshake shared with the divider.
module seq_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  input  logic        start,
  output logic [31:0] product,
  output logic        ready,
  output logic        done
);

  logic [31:0] r_mcand_sh;
  logic [15:0] r_mplier_sh;
  logic [31:0] r_product;
  logic [4:0]  r_count;
  logic        r_done;

  logic        w_ready;
  logic        w_accept;
  logic [31:0] w_sum;

  assign w_ready  = (r_count == 5'd0);
  assign w_accept = w_ready && start;
  // Max accumulated value is 0xFFFE0001, so a plain 32-bit add is enough.
  assign w_sum    = r_mplier_sh[0] ? (r_product + r_mcand_sh) : r_product;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand_sh  <= 32'd0;
      r_mplier_sh <= 16'd0;
      r_product   <= 32'd0;
      r_count     <= 5'd0;
      r_done      <= 1'b0;
    end else if (w_accept) begin
      r_mcand_sh  <= {16'd0, multiplicand};
      r_mplier_sh <= multiplier;
      r_product   <= 32'd0;
      r_count     <= 5'd16;
      r_done      <= 1'b0;
    end else if (r_count != 5'd0) begin
      r_product   <= w_sum;
      r_mcand_sh  <= {r_mcand_sh[30:0], 1'b0};
      r_mplier_sh <= {1'b0, r_mplier_sh[15:1]};
      r_count     <= r_count - 5'd1;
      r_done      <= (r_count == 5'd1);
    end else begin
      r_done      <= 1'b0;
    end
  end

  assign product = r_product;
  assign ready   = w_ready;
  assign done    = r_done;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a cycle-level reference model checked on every
// falling edge, plus directed vectors with hand-computed products.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        start;
  logic [31:0] product;
  logic        ready;
  logic        done;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  // Reference model state
  int          m_rem = 0;
  logic [31:0] m_exp = 32'd0;
  logic [31:0] m_prod = 32'd0;
  logic        m_done = 1'b0;

  seq_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .start        (start),
    .product      (product),
    .ready        (ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Model: accept computes A*B directly; result appears 16 edges later.
  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_prod = 32'd0; m_done = 1'b0;
    end else if (m_rem == 0 && start) begin
      m_exp  = {16'd0, multiplicand} * {16'd0, multiplier};
      m_rem  = 16; m_prod = 32'd0; m_done = 1'b0;
    end else if (m_rem != 0) begin
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      if (m_rem == 0) m_prod = m_exp;
    end else begin
      m_done = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    check("ready", {31'd0, ready}, {31'd0, (m_rem == 0)});
    check("done", {31'd0, done}, {31'd0, m_done});
    if (m_rem == 0) check("product", product, m_prod);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  // One full multiply; checks latency, result and a single done pulse.
  task automatic mul(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_lit);
    int lat;
    int d0;
    d0 = done_seen;
    multiplicand = a; multiplier = b; start = 1'b1;
    tick();
    start = 1'b0; multiplicand = ~a; multiplier = ~b;
    lat = 1;
    while (ready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, 17);
    check("result", product, exp_lit);
    tick();
    check("done_count", done_seen - d0, 1);
    $display("mul a=0x%04h b=0x%04h product=0x%08h latency=%0d", a, b, product, lat);
  endtask

  initial begin
    int d0;
    logic [15:0] ra, rb;
    logic [31:0] rexp;
    rst = 1'b1; start = 1'b0; multiplicand = 16'd0; multiplier = 16'd0;
    tick(); tick();
    // rst together with start: nothing accepted
    start = 1'b1; multiplicand = 16'd9; multiplier = 16'd9;
    tick();
    rst = 1'b0; start = 1'b0;
    check("reset_product", product, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    tick();
    $display("reset product=0x%08h ready=%0b done=%0b", product, ready, done);

    mul(16'd3, 16'd11, 32'h00000021);
    mul(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    mul(16'h1234, 16'h0000, 32'd0);
    mul(16'h0000, 16'hBEEF, 32'd0);

    // Start ignored while busy
    d0 = done_seen;
    multiplicand = 16'd5; multiplier = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    multiplicand = 16'd2; multiplier = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
    check("busy_ignore_result", product, 32'd35);
    repeat (3) tick();
    check("busy_ignore_dones", done_seen - d0, 1);
    $display("busy-ignore product=0x%08h", product);

    // Reset mid-operation
    d0 = done_seen;
    multiplicand = 16'h00FF; multiplier = 16'h0100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_product", product, 32'd0);
    repeat (20) tick();
    check("abort_no_done", done_seen - d0, 0);
    $display("abort product=0x%08h ready=%0b", product, ready);
    mul(16'd6, 16'd9, 32'd54);

    // start held high: back-to-back accepts at E0 and E17
    d0 = done_seen;
    multiplicand = 16'd7; multiplier = 16'd8; start = 1'b1;
    tick();
    multiplicand = 16'h8000; multiplier = 16'd2;
    repeat (16) tick();
    check("b2b_first", product, 32'd56);
    check("b2b_first_done", {31'd0, done}, 32'd1);
    $display("b2b first product=0x%08h", product);
    tick();
    start = 1'b0;
    check("b2b_second_busy", {31'd0, ready}, 32'd0);
    repeat (16) tick();
    check("b2b_second", product, 32'h00010000);
    check("b2b_second_done", {31'd0, done}, 32'd1);
    $display("b2b second product=0x%08h", product);
    tick();
    check("b2b_dones", done_seen - d0, 2);

    // Random pairs against plain A*B
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rexp = {16'd0, ra} * {16'd0, rb};
      mul(ra, rb, rexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential 16x16 unsigned shift-and-add multiplier producing a 32-bit product. It is the inverse-operation companion to the team's sequential divider and uses the same start/ready handshake, so the modular-exponentiation datapath of the Diffie-Hellman core can issue multiply and divide (reduce) operations through one control pattern. One partial product is accumulated per clock, giving a fixed 16-cycle busy period.

## Interface
Parameters:
- none. Width is fixed at 16-bit operands and a 32-bit product.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset. Sampled on the rising edge of clk; has priority over everything else.
- multiplicand  input  16  unsigned operand A. Sampled only on an accepted start.
- multiplier  input  16  unsigned operand B. Sampled only on an accepted start.
- start  input  1  request a multiply. Accepted only when ready=1.
- product  output  32  A*B. Valid whenever ready=1 after at least one completed operation.
- ready  output  1  idle / result valid. Combinationally equal to (count == 0).
- done  output  1  registered one-cycle pulse marking completion.

## Operation
Internal state:
- mcand_sh (32b): A, zero-extended, shifted left once per step.
- mplier_sh (16b): B, shifted right once per step.
- product (32b): accumulator.
- count (5b): steps remaining.
- done (1b).

Per rising edge, in priority order:
- rst=1: product=0, mcand_sh=0, mplier_sh=0, count=0, done=0.
- ready=1 and start=1 (accept): mcand_sh={16'd0,A}; mplier_sh=B; product=0; count=16; done=0.
- count!=0 (step):
  - if mplier_sh[0]=1, product = product + mcand_sh (32-bit add).
  - mcand_sh <<= 1; mplier_sh >>= 1; count = count-1.
  - done=1 if count was 1, else done=0.
- otherwise (idle): hold all state; done=0.

Arithmetic rules:
- The sum never exceeds 0xFFFE0001, so the 32-bit adder never overflows. No carry-out or saturation is required.
- Unsigned only; operands are not sign-extended.
- Exactly 16 steps always run. There is no early exit when mplier_sh becomes 0.

## Timing
Reset values: product=0, ready=1, done=0.

Cycle-level sequence:
- Accept edge E0: ready goes 0 after E0.
- Steps on E1..E16: product is intermediate (not valid) while ready=0.
- After E16: count=0, so ready=1 and done=1 for exactly one cycle. product holds A*B.
- Latency: 16 clocks from the accept edge to a valid result. Throughput: one result per 17 clocks at best, because a new start is accepted at E17 at the earliest.

Handshake rules:
- start while ready=0 is ignored. It is neither queued nor able to corrupt operands.
- Operands may change freely after E0.
- start held continuously issues back-to-back operations, re-accepted every 17th edge.
- product is held stable until the next accept, where it is cleared to 0.

Boundary conditions:
- rst asserted together with start: reset wins, and nothing is accepted.
- rst asserted mid-operation: the operation is aborted and ready=1 on the next cycle. No done pulse is issued.
- A=0 or B=0: still takes 16 cycles; product=0.
- After completion, done is deasserted in the same edge that accepts the next start (E17).

## Test plan
- Reset, then A=3, B=11, start for 1 cycle -> ready=0 for 16 cycles, then ready=1, done pulses once, product=0x00000021.
- A=0xFFFF, B=0xFFFF -> product=0xFFFE0001 after 16 cycles; no overflow.
- A=0x1234, B=0 and A=0, B=0xBEEF -> product=0 each time, 16-cycle latency unchanged.
- Start with A=5, B=7; at cycle 4 pulse start with A=2, B=2 -> second request ignored; product=35, only one done pulse.
- Start with A=0x00FF, B=0x0100; assert rst at cycle 8 -> next cycle product=0, ready=1, no done pulse. A fresh start with A=6, B=9 then yields product=54.
- start held high with operand pairs (7,8), (0x8000,2) -> accepts at E0 and E17; products 56 then 0x00010000; done pulses at 16 and 33.
- Randomized check: 1000 random operand pairs checked against a reference A*B.
